// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path: active-low glyph table,
// blank patterns and the per-slot phase type.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Cathodes {g,f,e,d,c,b,a}, active-low; codes A-F render as hex glyphs.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_phase_t;

    function automatic logic [3:0] anodeSel(input logic [1:0] d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 4-bit code to active-low seven-segment cathode pattern.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[code];

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit multiplexed display scanner with blanking interval, leading-zero
// suppression and frame-aligned commit of newly loaded values.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic        load_ack,
    output logic        frame_tick,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  an_out
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [15:0]   activeBcd;
    logic [3:0]    activeDp;
    logic [15:0]   pendBcd;
    logic [3:0]    pendDp;
    logic          pendV;

    logic          slotEnd;
    logic          frameEnd;
    slot_phase_t   phase;
    logic [3:0]    curCode;
    logic [6:0]    decodedSeg;
    logic [3:0]    lzBlank;

    assign slotEnd  = (cnt == CW'(TICK_DIV - 1));
    assign frameEnd = slotEnd && (dig == 2'd3);
    assign phase    = ((BLANK_CYC != 0) && (cnt < CW'(BLANK_CYC))) ? SLOT_BLANK : SLOT_SHOW;
    assign curCode  = activeBcd[{dig, 2'b00} +: 4];

    // Digit k is suppressed only when it and every more significant digit are zero.
    assign lzBlank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign lzBlank[gi] = blank_lz && (activeBcd[15:gi*4] == '0);
        end
    endgenerate

    seg_decode u_decode (
        .code (curCode),
        .seg  (decodedSeg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dig        <= '0;
            activeBcd  <= '0;
            activeDp   <= '0;
            pendBcd    <= '0;
            pendDp     <= '0;
            pendV      <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b1;
            an_out     <= AN_OFF;
        end else begin
            cnt <= slotEnd ? '0 : cnt + CW'(1);
            if (slotEnd) begin
                dig <= dig + 2'd1;
            end

            // A load on the boundary cycle skips pending so it appears next frame.
            if (frameEnd) begin
                if (load) begin
                    activeBcd <= bcd_in;
                    activeDp  <= dp_in;
                end else if (pendV) begin
                    activeBcd <= pendBcd;
                    activeDp  <= pendDp;
                end
                pendV <= 1'b0;
            end else if (load) begin
                pendBcd <= bcd_in;
                pendDp  <= dp_in;
                pendV   <= 1'b1;
            end

            load_ack   <= frameEnd && (load || pendV);
            frame_tick <= frameEnd;

            if (phase == SLOT_BLANK) begin
                an_out  <= AN_OFF;
                seg_out <= SEG_BLANK;
                dp_out  <= 1'b1;
            end else begin
                an_out  <= anodeSel(dig);
                seg_out <= lzBlank[dig] ? SEG_BLANK : decodedSeg;
                dp_out  <= ~activeDp[dig];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with an 8-cycle slot and 2-cycle blank.
module tb_seg_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        load_ack;
    logic        frame_tick;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;

    int total = 0;
    int bad = 0;
    int k = 0;

    seg_scan_scheduler #(.TICK_DIV(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .load_ack   (load_ack),
        .frame_tick (frame_tick),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .an_out     (an_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @k=%0d: got %0h want %0h", tag, k, got, exp);
        end else begin
            $display("ok   %s @k=%0d: %0h", tag, k, got);
        end
    endtask

    // k counts rising edges since reset release; sampling happens 2ns after each edge.
    task automatic step();
        @(posedge clk);
        k++;
        #2;
    endtask

    task automatic stepTo(input int n);
        while (k < n) step();
    endtask

    task automatic doLoad(input logic [15:0] v, input logic [3:0] d);
        bcd_in = v;
        dp_in  = d;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    int acks;
    int seen1;

    initial begin
        // 1. reset state and idle scan of 0000
        repeat (3) @(posedge clk);
        #2;
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'h1);
        check("rst_ack", 32'(load_ack), 32'h0);
        check("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;
        k = 0;
        stepTo(1);  check("s1_blank_an", 32'(an_out), 32'hF);
        stepTo(3);  check("s1_d0_an", 32'(an_out), 32'hE);
                    check("s1_d0_seg", 32'(seg_out), 32'h40);
                    check("s1_d0_dp", 32'(dp_out), 32'h1);
        stepTo(9);  check("s1_blank2_an", 32'(an_out), 32'hF);
        stepTo(11); check("s1_d1_an", 32'(an_out), 32'hD);
        stepTo(19); check("s1_d2_an", 32'(an_out), 32'hB);
        stepTo(27); check("s1_d3_an", 32'(an_out), 32'h7);
                    check("s1_d3_seg", 32'(seg_out), 32'h40);
        stepTo(31); check("s1_ft_early", 32'(frame_tick), 32'h0);
        stepTo(32); check("s1_ft_first", 32'(frame_tick), 32'h1);
                    check("s1_ack_idle", 32'(load_ack), 32'h0);
        stepTo(33); check("s1_ft_pulse", 32'(frame_tick), 32'h0);

        // 2. mid-frame load commits at the next boundary
        stepTo(40);
        doLoad(16'h1234, 4'b0100);
        stepTo(43); check("s2_hold_seg", 32'(seg_out), 32'h40);
        stepTo(63); check("s2_ack_early", 32'(load_ack), 32'h0);
        stepTo(64); check("s2_ack", 32'(load_ack), 32'h1);
                    check("s2_ft", 32'(frame_tick), 32'h1);
        stepTo(67); check("s2_d0_seg", 32'(seg_out), 32'h19);
                    check("s2_d0_dp", 32'(dp_out), 32'h1);
        stepTo(75); check("s2_d1_seg", 32'(seg_out), 32'h30);
                    check("s2_d1_dp", 32'(dp_out), 32'h1);
        stepTo(83); check("s2_d2_seg", 32'(seg_out), 32'h24);
                    check("s2_d2_dp", 32'(dp_out), 32'h0);
                    check("s2_d2_an", 32'(an_out), 32'hB);
        stepTo(91); check("s2_d3_seg", 32'(seg_out), 32'h79);

        // 3. overwrite before commit: latest wins, single ack
        stepTo(100);
        doLoad(16'h1111, 4'b0000);
        stepTo(105);
        doLoad(16'h2222, 4'b0000);
        acks = 0;
        seen1 = 0;
        while (k < 160) begin
            step();
            if (load_ack) acks++;
            if (k >= 129 && an_out != 4'hF && seg_out == 7'h79) seen1++;
            if (k == 128) check("s3_ack", 32'(load_ack), 32'h1);
            if (k == 131) check("s3_d0_seg", 32'(seg_out), 32'h24);
            if (k == 155) check("s3_d3_seg", 32'(seg_out), 32'h24);
        end
        check("s3_ack_count", 32'(acks), 32'd1);
        check("s3_no_1111", 32'(seen1), 32'd0);

        // 4. load on the boundary cycle bypasses into the next frame
        stepTo(191); check("s4_ack_pre", 32'(load_ack), 32'h0);
        doLoad(16'h0987, 4'b0000);
        check("s4_ack", 32'(load_ack), 32'h1);
        check("s4_ft", 32'(frame_tick), 32'h1);
        stepTo(195); check("s4_d0_seg", 32'(seg_out), 32'h78);
        stepTo(203); check("s4_d1_seg", 32'(seg_out), 32'h00);
        stepTo(211); check("s4_d2_seg", 32'(seg_out), 32'h10);
        stepTo(219); check("s4_d3_seg", 32'(seg_out), 32'h40);
        stepTo(224); check("s4_no_reack", 32'(load_ack), 32'h0);

        // 5. leading-zero blanking on 0050
        stepTo(230);
        blank_lz = 1'b1;
        doLoad(16'h0050, 4'b0000);
        stepTo(256); check("s5_ack", 32'(load_ack), 32'h1);
        stepTo(259); check("s5_d0_seg", 32'(seg_out), 32'h40);
        stepTo(267); check("s5_d1_seg", 32'(seg_out), 32'h12);
        stepTo(275); check("s5_d2_seg", 32'(seg_out), 32'h7F);
                     check("s5_d2_an", 32'(an_out), 32'hB);
        stepTo(283); check("s5_d3_seg", 32'(seg_out), 32'h7F);
        stepTo(284);
        blank_lz = 1'b0;
        stepTo(315); check("s5_nolz_d3_seg", 32'(seg_out), 32'h40);
                     check("s5_nolz_d3_an", 32'(an_out), 32'h7);

        // 6. asynchronous reset while a value is pending
        stepTo(320);
        doLoad(16'h4321, 4'b1111);
        stepTo(324); check("s6_pre_an", 32'(an_out), 32'hE);
        rst_n = 1'b0;
        #1;
        check("s6_async_an", 32'(an_out), 32'hF);
        check("s6_async_seg", 32'(seg_out), 32'h7F);
        check("s6_async_dp", 32'(dp_out), 32'h1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        k = 0;
        acks = 0;
        while (k < 40) begin
            step();
            if (load_ack) acks++;
            if (k == 3)  check("s6_d0_seg", 32'(seg_out), 32'h40);
            if (k == 27) check("s6_d3_seg", 32'(seg_out), 32'h40);
            if (k == 32) check("s6_ft", 32'(frame_tick), 32'h1);
        end
        check("s6_no_ack", 32'(acks), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
